// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, pipelined imem requests, DEPTH-entry in-order queue to decode.
// Optional FETCH_MISALIGN_EN: misaligned redirect halts fetch and presents one fault entry.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  output logic        o_id_fault
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
  localparam logic [AW+1:0]   DEPTH_W = (AW+2)'(DEPTH);

  logic              r_run;
  logic [31:0]       r_pc;
  logic [AW:0]       r_head, r_tail, r_fill, r_drop_cnt;
  logic [31:0]       r_q_pc    [DEPTH];
  logic [31:0]       r_q_instr [DEPTH];
  logic [DEPTH-1:0]  r_q_filled;

  logic [AW:0]       w_count, w_unfilled;
  logic [AW+1:0]     w_inflight, w_outstanding, w_redir_drop;
  logic [AW-1:0]     w_head_idx;
  logic              w_grant, w_pop, w_rsp_drop, w_rsp_fill, w_halt;
  logic [31:0]       w_redirect_pc;

`ifdef FETCH_MISALIGN_EN
  logic              r_halt;
  logic [DEPTH-1:0]  r_q_fault;
  logic              w_misalign;
  assign w_misalign    = |i_redirect_pc[1:0];
  assign w_redirect_pc = i_redirect_pc;
  assign w_halt        = r_halt;
`else
  logic              w_unused_pc_lsb;
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];
  assign w_redirect_pc   = {i_redirect_pc[31:2], 2'b00};
  assign w_halt          = 1'b0;
`endif

  // fill pointer marks the oldest entry still waiting for its response
  assign w_count       = r_tail - r_head;
  assign w_unfilled    = r_tail - r_fill;
  assign w_inflight    = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign w_outstanding = {1'b0, w_unfilled} + {1'b0, r_drop_cnt};
  assign w_redir_drop  = w_outstanding - (AW+2)'(i_imem_rvalid && (w_outstanding != '0));
  assign w_rsp_drop    = i_imem_rvalid && (r_drop_cnt != '0);
  assign w_rsp_fill    = i_imem_rvalid && (r_drop_cnt == '0) && (w_unfilled != '0);
  assign w_head_idx    = r_head[AW-1:0];

  assign o_imem_req  = r_run && !w_halt && !i_redirect_valid && (w_inflight < DEPTH_W);
  assign o_imem_addr = r_pc;
  assign w_grant     = o_imem_req && i_imem_gnt;
  assign o_id_valid  = (w_count != '0) && r_q_filled[w_head_idx];
  assign o_id_instr  = r_q_instr[w_head_idx];
  assign o_id_pc     = r_q_pc[w_head_idx];
  assign w_pop       = o_id_valid && i_id_ready;
`ifdef FETCH_MISALIGN_EN
  assign o_id_fault  = r_q_fault[w_head_idx];
`else
  assign o_id_fault  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_drop_cnt <= '0;
      r_q_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_pc[i]    <= '0;
        r_q_instr[i] <= '0;
      end
`ifdef FETCH_MISALIGN_EN
      r_halt    <= 1'b0;
      r_q_fault <= '0;
`endif
    end else begin
      r_run <= 1'b1;
      if (i_redirect_valid) begin
        // in-flight responses are not cancellable, so count them off as drops
        r_head     <= '0;
        r_tail     <= '0;
        r_fill     <= '0;
        r_q_filled <= '0;
        r_pc       <= w_redirect_pc;
        r_drop_cnt <= w_redir_drop[AW:0];
`ifdef FETCH_MISALIGN_EN
        r_halt    <= w_misalign;
        r_q_fault <= '0;
        if (w_misalign) begin
          r_q_pc[0]     <= i_redirect_pc;
          r_q_instr[0]  <= 32'h0000_0013;
          r_q_filled[0] <= 1'b1;
          r_q_fault[0]  <= 1'b1;
          r_tail        <= PTR_ONE;
          r_fill        <= PTR_ONE;
        end
`endif
      end else begin
        if (w_grant) begin
          r_q_pc[r_tail[AW-1:0]]     <= r_pc;
          r_q_filled[r_tail[AW-1:0]] <= 1'b0;
`ifdef FETCH_MISALIGN_EN
          r_q_fault[r_tail[AW-1:0]]  <= 1'b0;
`endif
          r_tail <= r_tail + PTR_ONE;
          r_pc   <= r_pc + 32'd4;
        end
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - PTR_ONE;
        if (w_rsp_fill) begin
          r_q_instr[r_fill[AW-1:0]]  <= i_imem_rdata;
          r_q_filled[r_fill[AW-1:0]] <= 1'b1;
          r_fill <= r_fill + PTR_ONE;
        end
        if (w_pop) r_head <= r_head + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency instruction memory model.
// Memory returns mem_f(addr); FETCH_MISALIGN_EN selects the fault-entry checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b1;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_id_valid;
  logic        i_id_ready = 1'b1;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic        o_id_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int n_grant = 0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_id_valid(o_id_valid), .i_id_ready(i_id_ready),
    .o_id_instr(o_id_instr), .o_id_pc(o_id_pc), .o_id_fault(o_id_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock: log grant/response at the pre-edge values, then drive the next cycle's response
  task automatic tick();
    if (rst_n) begin
      if (o_imem_req && i_imem_gnt) begin
        pend_addr.push_back(o_imem_addr);
        pend_due.push_back(cyc + lat);
        n_grant++;
      end
      if (i_imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    i_imem_rvalid    = 1'b0;
    i_imem_rdata     = '0;
    i_redirect_valid = 1'b0;
    if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mem_f(pend_addr[0]);
    end
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = pc;
    #1;
  endtask

  task automatic enter_reset(input int new_lat);
    rst_n = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    i_imem_rvalid    = 1'b0;
    i_redirect_valid = 1'b0;
    i_id_ready       = 1'b1;
    lat              = new_lat;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    cyc     = 0;
    n_grant = 0;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!o_id_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(o_id_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] exp_pc;
    enter_reset(1);
    chk("rst_req",   32'(o_imem_req), 32'd0);
    chk("rst_addr",  o_imem_addr, 32'h0);
    chk("rst_valid", 32'(o_id_valid), 32'd0);
    chk("rst_instr", o_id_instr, 32'h0);
    chk("rst_pc",    o_id_pc, 32'h0);
    chk("rst_fault", 32'(o_id_fault), 32'd0);

    // streaming with single-cycle memory
    release_reset();
    chk("s_req_c1",   32'(o_imem_req), 32'd1);
    chk("s_addr_c1",  o_imem_addr, 32'h0);
    chk("s_valid_c1", 32'(o_id_valid), 32'd0);
    tick();
    chk("s_addr_c2",  o_imem_addr, 32'h4);
    chk("s_valid_c2", 32'(o_id_valid), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("s_valid", 32'(o_id_valid), 32'd1);
      chk("s_pc",    o_id_pc, 32'(4 * k));
      chk("s_instr", o_id_instr, mem_f(32'(4 * k)));
      tick();
    end

    // backpressure fills the queue, then drains in order
    enter_reset(1);
    i_id_ready = 1'b0;
    release_reset();
    repeat (10) tick();
    chk("bp_grants", 32'(n_grant), 32'd4);
    chk("bp_req",    32'(o_imem_req), 32'd0);
    chk("bp_valid",  32'(o_id_valid), 32'd1);
    chk("bp_pc",     o_id_pc, 32'h0);
    chk("bp_instr",  o_id_instr, mem_f(32'h0));
    i_id_ready = 1'b1;
    #1;
    exp_pc = 32'h0;
    for (int k = 0; k < 6; k++) begin
      chk("bp_drain_valid", 32'(o_id_valid), 32'd1);
      chk("bp_drain_pc",    o_id_pc, exp_pc);
      exp_pc = exp_pc + 32'd4;
      tick();
    end

    // redirect with three requests outstanding on a slow memory
    enter_reset(4);
    release_reset();
    repeat (3) tick();
    chk("rd_inflight", 32'(n_grant), 32'd3);
    redirect(32'h100);
    chk("rd_req_R", 32'(o_imem_req), 32'd0);
    tick();
    chk("rd_req_R1",   32'(o_imem_req), 32'd1);
    chk("rd_addr_R1",  o_imem_addr, 32'h100);
    chk("rd_valid_R1", 32'(o_id_valid), 32'd0);
    wait_valid("rd");
    chk("rd_pc",    o_id_pc, 32'h100);
    chk("rd_instr", o_id_instr, mem_f(32'h100));
    tick();
    chk("rd_pc2", o_id_pc, 32'h104);

    // redirect coinciding with a response and a pop
    enter_reset(1);
    release_reset();
    tick();
    tick();
    chk("rc_pre_pc", o_id_pc, 32'h0);
    redirect(32'h40);
    tick();
    chk("rc_valid_R1", 32'(o_id_valid), 32'd0);
    chk("rc_addr_R1",  o_imem_addr, 32'h40);
    wait_valid("rc");
    chk("rc_pc",    o_id_pc, 32'h40);
    chk("rc_instr", o_id_instr, mem_f(32'h40));
    tick();
    chk("rc_pc2", o_id_pc, 32'h44);

    // misaligned redirect
    enter_reset(1);
    release_reset();
    tick();
    tick();
    redirect(32'h102);
    tick();
`ifdef FETCH_MISALIGN_EN
    chk("ma_valid", 32'(o_id_valid), 32'd1);
    chk("ma_pc",    o_id_pc, 32'h102);
    chk("ma_instr", o_id_instr, 32'h0000_0013);
    chk("ma_fault", 32'(o_id_fault), 32'd1);
    chk("ma_req",   32'(o_imem_req), 32'd0);
    tick();
    chk("ma_popped", 32'(o_id_valid), 32'd0);
    repeat (3) tick();
    chk("ma_halted", 32'(o_imem_req), 32'd0);
    redirect(32'h200);
    tick();
    chk("ma_resume_req",  32'(o_imem_req), 32'd1);
    chk("ma_resume_addr", o_imem_addr, 32'h200);
    wait_valid("ma");
    chk("ma_resume_pc",    o_id_pc, 32'h200);
    chk("ma_resume_fault", 32'(o_id_fault), 32'd0);
`else
    chk("ma_req",   32'(o_imem_req), 32'd1);
    chk("ma_addr",  o_imem_addr, 32'h100);
    chk("ma_valid", 32'(o_id_valid), 32'd0);
    wait_valid("ma");
    chk("ma_pc",    o_id_pc, 32'h100);
    chk("ma_instr", o_id_instr, mem_f(32'h100));
    chk("ma_fault", 32'(o_id_fault), 32'd0);
`endif

    // asynchronous reset with responses outstanding
    enter_reset(3);
    release_reset();
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   32'(o_imem_req), 32'd0);
    chk("ar_addr",  o_imem_addr, 32'h0);
    chk("ar_valid", 32'(o_id_valid), 32'd0);
    chk("ar_instr", o_id_instr, 32'h0);
    chk("ar_pc",    o_id_pc, 32'h0);
    chk("ar_fault", 32'(o_id_fault), 32'd0);
    enter_reset(1);
    release_reset();
    chk("ar_post_req",  32'(o_imem_req), 32'd1);
    chk("ar_post_addr", o_imem_addr, 32'h0);
    tick();
    tick();
    chk("ar_post_valid", 32'(o_id_valid), 32'd1);
    chk("ar_post_pc",    o_id_pc, 32'h0);
    chk("ar_post_instr", o_id_instr, mem_f(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
